// File: rtl/management_regs_pkg.sv
// Shared address map, window sizes and status bit positions for the
// management register interface.
package management_regs_pkg;

  localparam logic [15:0] ADDR_IDCODE  = 16'h0000;
  localparam logic [15:0] ADDR_SERIAL  = 16'h0004;
  localparam logic [15:0] ADDR_STATUS  = 16'h000C;
  localparam logic [15:0] ADDR_CRYPT_E = 16'h0020;
  localparam logic [15:0] ADDR_WORK_IN = 16'h0040;
  localparam logic [15:0] ADDR_RESULT  = 16'h0060;
  localparam logic [15:0] ADDR_CMD     = 16'h0080;
  localparam logic [15:0] ADDR_VLAN    = 16'h0100;

  localparam int SIZE_IDCODE = 4;
  localparam int SIZE_SERIAL = 8;
  localparam int SIZE_OPND   = 32;

  localparam int STAT_IDCODE_VALID = 0;
  localparam int STAT_SERIAL_VALID = 1;
  localparam int STAT_CRYPT_BUSY   = 2;
  localparam int STAT_CRYPT_DONE   = 3;

  // True when addr lies in [base, base+size); 17-bit math avoids wrap at 0xFFFF.
  function automatic logic in_win(input logic [15:0] addr,
                                  input logic [15:0] base,
                                  input int          size);
    return ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} <  ({1'b0, base} + 17'(size)));
  endfunction

endpackage

// File: rtl/mgmt_byte_reg256.sv
// 256-bit register written one byte at a time, with a combinational byte
// read port. Holds one X25519 operand.
module mgmt_byte_reg256 (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [4:0]   wr_idx,
  input  logic [7:0]   wr_data,
  input  logic [4:0]   rd_idx,
  output logic [7:0]   rd_byte,
  output logic [255:0] q
);

  logic [255:0] r_q;

  // Byte write; byte 0 is bits [7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (wr_en) begin
      r_q[{wr_idx, 3'b000} +: 8] <= wr_data;
    end
  end

  assign rd_byte = r_q[{rd_idx, 3'b000} +: 8];
  assign q       = r_q;

endmodule

// File: rtl/management_register_interface.sv
// Byte-wide management register file: device identity, per-port VLAN IDs
// and a start/complete handshake to an external X25519 engine.
module management_register_interface
  import management_regs_pkg::*;
#(
  parameter int NUM_PORTS  = 15,
  parameter int VLAN_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic [15:0]                     rd_addr,
  output logic                            rd_valid,
  output logic [7:0]                      rd_data,
  input  logic                            wr_en,
  input  logic [15:0]                     wr_addr,
  input  logic [7:0]                      wr_data,
  input  logic                            die_serial_valid,
  input  logic [63:0]                     die_serial,
  input  logic                            idcode_valid,
  input  logic [31:0]                     idcode,
  output logic [NUM_PORTS*VLAN_WIDTH-1:0] port_rx_vlan,
  output logic                            crypt_en,
  output logic [255:0]                    crypt_work_in,
  output logic [255:0]                    crypt_e,
  input  logic                            crypt_out_valid,
  input  logic [255:0]                    crypt_work_out
);

  logic [VLAN_WIDTH-1:0] r_vlan [NUM_PORTS];
  logic [255:0]          r_result;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_crypt_en;
  logic                  r_rd_valid;
  logic [7:0]            r_rd_data;

  logic                  w_e_wr;
  logic                  w_wi_wr;
  logic                  w_cmd_wr;
  logic [7:0]            w_e_byte;
  logic [7:0]            w_wi_byte;
  logic [7:0]            w_status;
  logic [2:0]            w_ser_off;
  logic [7:0]            w_rd_byte;

  assign w_e_wr   = wr_en && in_win(wr_addr, ADDR_CRYPT_E, SIZE_OPND);
  assign w_wi_wr  = wr_en && in_win(wr_addr, ADDR_WORK_IN, SIZE_OPND);
  assign w_cmd_wr = wr_en && (wr_addr == ADDR_CMD);

  mgmt_byte_reg256 u_crypt_e (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_e_wr),
    .wr_idx  (wr_addr[4:0]),
    .wr_data (wr_data),
    .rd_idx  (rd_addr[4:0]),
    .rd_byte (w_e_byte),
    .q       (crypt_e)
  );

  mgmt_byte_reg256 u_work_in (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wi_wr),
    .wr_idx  (wr_addr[4:0]),
    .wr_data (wr_data),
    .rd_idx  (rd_addr[4:0]),
    .rd_byte (w_wi_byte),
    .q       (crypt_work_in)
  );

  // Per-port VLAN registers; the high byte only stores bits [VLAN_WIDTH-1:8].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) r_vlan[p] <= VLAN_WIDTH'(1);
    end else if (wr_en) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_addr == 16'(ADDR_VLAN + 16'(2 * p))) begin
          r_vlan[p] <= {r_vlan[p][VLAN_WIDTH-1:8], wr_data};
        end else if (wr_addr == 16'(ADDR_VLAN + 16'(2 * p + 1))) begin
          r_vlan[p] <= VLAN_WIDTH'({wr_data, r_vlan[p][7:0]});
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_vlan_out
    assign port_rx_vlan[g*VLAN_WIDTH +: VLAN_WIDTH] = r_vlan[g];
  end

  // Engine handshake. A command arriving in the same cycle as a completion
  // (engine idle) starts the new operation, so it wins busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crypt_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_crypt_en <= 1'b0;
      if (crypt_out_valid) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_cmd_wr && !r_busy) begin
        r_crypt_en <= 1'b1;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end
    end
  end

  // Result capture; a completion strobe is always captured, even when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (crypt_out_valid) begin
      r_result <= crypt_work_out;
    end
  end

  // Status byte assembled from the live valid flags and handshake state.
  always_comb begin
    w_status                    = 8'h00;
    w_status[STAT_IDCODE_VALID] = idcode_valid;
    w_status[STAT_SERIAL_VALID] = die_serial_valid;
    w_status[STAT_CRYPT_BUSY]   = r_busy;
    w_status[STAT_CRYPT_DONE]   = r_done;
  end

  // Read decode from current register state, so a same-cycle write is not seen.
  always_comb begin
    w_rd_byte = 8'h00;
    w_ser_off = rd_addr[2:0] - 3'd4;
    if (in_win(rd_addr, ADDR_IDCODE, SIZE_IDCODE)) begin
      w_rd_byte = idcode[{rd_addr[1:0], 3'b000} +: 8];
    end else if (in_win(rd_addr, ADDR_SERIAL, SIZE_SERIAL)) begin
      w_rd_byte = die_serial[{w_ser_off, 3'b000} +: 8];
    end else if (rd_addr == ADDR_STATUS) begin
      w_rd_byte = w_status;
    end else if (in_win(rd_addr, ADDR_CRYPT_E, SIZE_OPND)) begin
      w_rd_byte = w_e_byte;
    end else if (in_win(rd_addr, ADDR_WORK_IN, SIZE_OPND)) begin
      w_rd_byte = w_wi_byte;
    end else if (in_win(rd_addr, ADDR_RESULT, SIZE_OPND)) begin
      w_rd_byte = r_result[{rd_addr[4:0], 3'b000} +: 8];
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_addr == 16'(ADDR_VLAN + 16'(2 * p))) begin
          w_rd_byte = r_vlan[p][7:0];
        end else if (rd_addr == 16'(ADDR_VLAN + 16'(2 * p + 1))) begin
          w_rd_byte = 8'(r_vlan[p] >> 8);
        end
      end
    end
  end

  // One-cycle read response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_data  <= rd_en ? w_rd_byte : 8'h00;
    end
  end

  // Reset masks strobes immediately so a response due during reset is dropped.
  assign rd_valid = r_rd_valid && !rst;
  assign rd_data  = rst ? 8'h00 : r_rd_data;
  assign crypt_en = r_crypt_en && !rst;

endmodule

// File: tb/tb_management_register_interface.sv
// Directed bench for management_register_interface.
module tb_management_register_interface;

  localparam int NP = 15;
  localparam int VW = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           rd_en;
  logic [15:0]    rd_addr;
  logic           rd_valid;
  logic [7:0]     rd_data;
  logic           wr_en;
  logic [15:0]    wr_addr;
  logic [7:0]     wr_data;
  logic           die_serial_valid;
  logic [63:0]    die_serial;
  logic           idcode_valid;
  logic [31:0]    idcode;
  logic [NP*VW-1:0] port_rx_vlan;
  logic           crypt_en;
  logic [255:0]   crypt_work_in;
  logic [255:0]   crypt_e;
  logic           crypt_out_valid;
  logic [255:0]   crypt_work_out;

  int n_total = 0;
  int n_pass  = 0;

  management_register_interface #(.NUM_PORTS(NP), .VLAN_WIDTH(VW)) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .die_serial_valid (die_serial_valid),
    .die_serial       (die_serial),
    .idcode_valid     (idcode_valid),
    .idcode           (idcode),
    .port_rx_vlan     (port_rx_vlan),
    .crypt_en         (crypt_en),
    .crypt_work_in    (crypt_work_in),
    .crypt_e          (crypt_e),
    .crypt_out_valid  (crypt_out_valid),
    .crypt_work_out   (crypt_work_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Single read: checks the response arrives exactly one edge later.
  task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    check({tag, "_vld"}, 256'(rd_valid), 256'(1));
    check(tag, 256'(rd_data), 256'(exp));
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    die_serial_valid = 1'b0; die_serial = '0; idcode_valid = 1'b0; idcode = '0;
    crypt_out_valid = 1'b0; crypt_work_out = '0;
    tick(); tick();

    // Reset state
    check("rst_rd_valid", 256'(rd_valid), 256'(0));
    check("rst_rd_data", 256'(rd_data), 256'(0));
    check("rst_crypt_en", 256'(crypt_en), 256'(0));
    check("rst_vlan_all", 256'(port_rx_vlan), 256'({NP{12'h001}}));
    check("rst_crypt_e", crypt_e, 256'(0));
    rst = 1'b0;
    tick();

    // Read latency and default VLAN contents
    rd_en = 1'b1; rd_addr = 16'h0100;
    check("lat_pre_vld", 256'(rd_valid), 256'(0));
    tick();
    rd_en = 1'b0;
    check("lat_vld", 256'(rd_valid), 256'(1));
    check("vlan0_lo", 256'(rd_data), 256'(8'h01));
    tick();
    check("lat_post_vld", 256'(rd_valid), 256'(0));
    do_read("vlan0_hi", 16'h0101, 8'h00);
    do_read("cmd_rd", 16'h0080, 8'h00);
    do_read("unmapped", 16'h0200, 8'h00);
    do_read("vlan_last_hi", 16'h011D, 8'h00);
    do_read("vlan_beyond", 16'h011E, 8'h00);

    // IDCODE back-to-back reads
    idcode = 32'h03631093; idcode_valid = 1'b1;
    rd_en = 1'b1; rd_addr = 16'h0000;
    tick(); check("id_b0", 256'(rd_data), 256'(8'h93)); rd_addr = 16'h0001;
    tick(); check("id_b1", 256'(rd_data), 256'(8'h10)); rd_addr = 16'h0002;
    tick(); check("id_b2", 256'(rd_data), 256'(8'h63)); rd_addr = 16'h0003;
    tick(); check("id_b3", 256'(rd_data), 256'(8'h03));
    check("id_b3_vld", 256'(rd_valid), 256'(1));
    rd_en = 1'b0;
    tick();
    check("id_end_vld", 256'(rd_valid), 256'(0));
    do_read("status_id", 16'h000C, 8'h01);

    // Die serial reads live value with valid low
    idcode_valid = 1'b0;
    die_serial = 64'h1122334455667788;
    do_read("ser_b0", 16'h0004, 8'h88);
    do_read("ser_b7", 16'h000B, 8'h11);
    do_read("id_ro_check", 16'h0000, 8'h93);
    do_write(16'h0000, 8'h5A);
    do_read("id_after_wr", 16'h0000, 8'h93);

    // VLAN write to port 1
    do_write(16'h0102, 8'hAB);
    do_write(16'h0103, 8'hFF);
    check("vlan1", 256'(port_rx_vlan[VW +: VW]), 256'(12'hFAB));
    check("vlan0_keep", 256'(port_rx_vlan[0 +: VW]), 256'(12'h001));
    check("vlan14_keep", 256'(port_rx_vlan[14*VW +: VW]), 256'(12'h001));
    do_read("vlan1_lo", 16'h0102, 8'hAB);
    do_read("vlan1_hi", 16'h0103, 8'h0F);

    // Same-cycle read and write returns the old value
    rd_en = 1'b1; rd_addr = 16'h0020;
    wr_en = 1'b1; wr_addr = 16'h0020; wr_data = 8'h55;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_same_old", 256'(rd_data), 256'(8'h00));
    do_read("rw_same_new", 16'h0020, 8'h55);

    // Operand load and crypt start
    for (int i = 0; i < 32; i++) do_write(16'(16'h0020 + i), 8'(i + 1));
    for (int i = 0; i < 32; i++) do_write(16'(16'h0040 + i), 8'(8'hA0 + i));
    check("e_b0", 256'(crypt_e[7:0]), 256'(8'h01));
    check("e_b31", 256'(crypt_e[255:248]), 256'(8'h20));
    check("wi_b1", 256'(crypt_work_in[15:8]), 256'(8'hA1));
    do_read("wi_rd_b2", 16'h0042, 8'hA2);
    check("en_idle", 256'(crypt_en), 256'(0));
    do_write(16'h0080, 8'h00);
    check("en_pulse", 256'(crypt_en), 256'(1));
    tick();
    check("en_one_cycle", 256'(crypt_en), 256'(0));
    do_read("status_busy", 16'h000C, 8'h04);
    do_write(16'h0080, 8'h01);
    check("en_busy_ignored", 256'(crypt_en), 256'(0));
    do_write(16'h0021, 8'h77);
    check("e_wr_while_busy", 256'(crypt_e[15:8]), 256'(8'h77));

    // Completion
    crypt_work_out = 256'h0102; crypt_out_valid = 1'b1;
    tick();
    crypt_out_valid = 1'b0;
    do_read("status_done", 16'h000C, 8'h08);
    do_read("res_b0", 16'h0060, 8'h02);
    do_read("res_b1", 16'h0061, 8'h01);

    // Reset mid-crypt, with a read in flight
    do_write(16'h0080, 8'h00);
    rd_en = 1'b1; rd_addr = 16'h0102;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_drops_rsp", 256'(rd_valid), 256'(0));
    tick();
    rst = 1'b0;
    check("rst_vlan1", 256'(port_rx_vlan[VW +: VW]), 256'(12'h001));
    check("rst_work_in", crypt_work_in, 256'(0));
    do_read("status_after_rst", 16'h000C, 8'h00);
    do_read("res_after_rst", 16'h0060, 8'h00);
    crypt_work_out = 256'hBEEF; crypt_out_valid = 1'b1;
    tick();
    crypt_out_valid = 1'b0;
    do_read("status_late_done", 16'h000C, 8'h08);
    do_read("res_late_b1", 16'h0061, 8'hBE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
